// File: rtl/instr_injector.sv
// rtl/instr_injector.sv - program-buffer instruction sequencer for the CPU switch-instruction path
// Optional running checksum on trace_sum enabled by defining INJ_TRACE_EN.
module instr_injector #(
  parameter int DATA_W                = 16,
  parameter int DEPTH                 = 32,
  parameter int ADDR_W                = 5,
  parameter logic [DATA_W-1:0] NOP_WORD = 16'h0800,
  parameter int DRAIN_CYCLES          = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic [ADDR_W:0]   prog_len,
  input  logic [7:0]        repeat_cnt,
  input  logic              start,
  input  logic              step_mode,
  input  logic              step,
  input  logic              stall,
  output logic [DATA_W-1:0] instr_out,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc_out,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] trace_sum
);

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        pass_q, pass_d;
  logic [7:0]        rep_q, rep_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  dcnt_q, dcnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              advance;
  logic              at_last;
  logic [ADDR_W-1:0] pc_inc;

  // Program buffer survives reset so a reloaded bench can simply restart.
  always_ff @(posedge clk) begin
    if (load_en) mem_q[load_addr] <= load_data;
  end

  assign advance = !stall && (!step_mode || step);
  assign at_last = ({1'b0, pc_q} == (len_q - 1'b1));
  assign pc_inc  = pc_q + 1'b1;

`ifdef INJ_TRACE_EN
  logic [DATA_W-1:0] trace_q, trace_d;
  assign trace_sum = trace_q;
`else
  assign trace_sum = '0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pass_d  = pass_q;
    rep_d   = rep_q;
    len_d   = len_q;
    out_d   = out_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    dcnt_d  = dcnt_q;
`ifdef INJ_TRACE_EN
    trace_d = trace_q;
`endif
    case (state_q)
      S_IDLE: begin
        out_d   = NOP_WORD;
        valid_d = 1'b0;
        if (start && (prog_len != '0) && (prog_len <= DEPTH_L)) begin
          state_d = S_RUN;
          pc_d    = '0;
          pass_d  = '0;
          len_d   = prog_len;
          rep_d   = repeat_cnt;
          out_d   = mem_q[0];
          valid_d = 1'b1;
`ifdef INJ_TRACE_EN
          trace_d = '0;
`endif
        end
      end
      S_RUN: begin
        // The output word is captured together with pc, so a later buffer
        // write never disturbs the word already being presented.
        if (advance) begin
`ifdef INJ_TRACE_EN
          trace_d = {trace_q[DATA_W-2:0], trace_q[DATA_W-1]} ^ out_q;
`endif
          if (!at_last) begin
            pc_d  = pc_inc;
            out_d = mem_q[pc_inc];
          end else if (pass_q < rep_q) begin
            pc_d   = '0;
            pass_d = pass_q + 8'd1;
            out_d  = mem_q[0];
          end else begin
            state_d = S_DRAIN;
            pc_d    = '0;
            dcnt_d  = '0;
            out_d   = NOP_WORD;
            valid_d = 1'b0;
          end
        end
      end
      S_DRAIN: begin
        if (!stall) begin
          if (dcnt_q == DRAIN_LAST) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            dcnt_d = dcnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      pass_q  <= '0;
      rep_q   <= '0;
      len_q   <= '0;
      out_q   <= NOP_WORD;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      dcnt_q  <= '0;
`ifdef INJ_TRACE_EN
      trace_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pass_q  <= pass_d;
      rep_q   <= rep_d;
      len_q   <= len_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      dcnt_q  <= dcnt_d;
`ifdef INJ_TRACE_EN
      trace_q <= trace_d;
`endif
    end
  end

  assign instr_out   = out_q;
  assign instr_valid = valid_q;
  assign pc_out      = pc_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;

endmodule
